counter_main: RTL and testbench
===============================

// Module: counter_main
// PURPOSE
//  Time-credit counter for a coin-operated charging station. Each inserted coin
//  buys a fixed amount of charging time. The remaining time counts down once per
//  tick while the mode is enabled, and is shown as BCD M:SS on PresentTime for the
//  display/driver stage downstream.
// PARAMETERS
//  TICK_DIV  1  enabled Clk cycles per one-second decrement (1 = every cycle, for sim)
// PORTS
//  Clk          in   1   system clock; all state updates on rising edge
//  nReset       in   1   asynchronous, active-low reset
//  ModeEnable   in   1   1 = accept coins and count down; 0 = freeze (hold time, ignore coins)
//  Coin         in   3   coin code; 0 = no coin; nonzero code = coin present
//  PresentTime  out  12  BCD remaining time: [11:8] minutes 0-9, [7:4] tens of s 0-5, [3:0] s 0-9
// BEHAVIOUR
//  Reset (nReset=0, async):
//   - PresentTime = 12'h000; previous-coin register = 0; tick prescaler = 0.
//   - Reset mid-countdown discards all remaining credit.
//  Coin decode (credit added, in seconds):
//   1 -> 0:10, 2 -> 0:20, 3 -> 0:30, 4 -> 1:00, 5 -> 1:30, 6 -> 2:00, 7 -> 5:00.
//  Coin acceptance:
//   - A coin is accepted on a clock edge when ModeEnable=1, Coin!=0, and Coin != the
//     registered previous Coin value.
//   - The previous-Coin register updates every cycle regardless of ModeEnable.
//   - A code held constant is credited once only. Return Coin to 0, or change the
//     code, to insert again.
//  Tick:
//   - Prescaler counts enabled cycles 0..TICK_DIV-1; tick asserts on the cycle it equals
//     TICK_DIV-1, then it wraps to 0.
//   - Prescaler holds while ModeEnable=0.
//  Next-state, per edge with ModeEnable=1:
//   - t = PresentTime in seconds (0..599).
//   - t1 = (tick && t!=0 && no coin accepted this edge) ? t-1 : t.
//   - t2 = t1 + credit (0 if no coin).
//   - Saturate at 599 (9:59); excess credit is lost.
//   - Acceptance edge: add only, no decrement.
//  Countdown:
//   - At 0:00 the countdown stops and holds 0:00; there is no wrap to 9:59.
//  BCD rules:
//   - Decrement borrows s 0->9 with tens-1, and tens 0->5 with minutes-1
//     (e.g. 1:00 -> 0:59, 0:10 -> 0:09).
//   - Output always holds legal BCD; digits never exceed 9/5/9.
//  Latency and output:
//   - Accepted coin is visible on PresentTime the same edge it is sampled (1-cycle latency).
//   - Output is registered; no combinational path from inputs to PresentTime.
//  ModeEnable=0: PresentTime, prescaler hold; coins not credited (still tracked as previous).
//  Internal arithmetic may be binary seconds with BCD conversion, or native BCD;
//   only the port encoding is fixed.
// TESTING
//  1. Reset: nReset=0 any inputs -> PresentTime=12'h000 immediately (async), held.
//  2. Coin=5 held, ModeEnable=1, TICK_DIV=1, release reset at 10ns:
//     - first edge (15ns) -> 12'h130 (1:30);
//     - next edge -> 12'h129; 1:00 -> 0:59 borrow;
//     - 12'h000 at 915ns, then holds 0:00 to 2010ns with no re-credit.
//  3. Coin sequence 4,0,4 (one cycle each) from 0:00 -> 1:00 credited twice
//     (2:00 minus decrements); codes 3 then 7 back-to-back both credited.
//  4. Saturation: at 9:00 insert 7 -> 9:59 exactly, then counts 9:58.
//  5. ModeEnable=0 for 20 cycles at 0:45 with coin 4 pulsed -> stays 12'h045, no credit;
//     re-enable -> resumes 0:44.
//  6. TICK_DIV=4: 0:10 decrements every 4th enabled edge; async reset mid-count
//     -> 12'h000 immediately.

Source files
------------

// File: rtl/counter_main.sv
// Coin-credit countdown timer for a charging station.
// Remaining time is held as BCD M:SS. Each cycle's update is done in binary seconds.
module counter_main #(
  parameter int TICK_DIV = 1
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        ModeEnable,
  input  logic [2:0]  Coin,
  output logic [11:0] PresentTime
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [9:0]    T_MAX   = 10'd599;

  logic [11:0]   time_q, time_d;
  logic [2:0]    prev_q, prev_d;
  logic [PW-1:0] pre_q,  pre_d;

  logic [9:0]  secs, t1, t2, credit, rem_s;
  logic [10:0] sum;
  logic        accept, tick;
  logic [3:0]  m_dig, t_dig, s_dig;

  always_comb begin
    case (Coin)
      3'd1:    credit = 10'd10;
      3'd2:    credit = 10'd20;
      3'd3:    credit = 10'd30;
      3'd4:    credit = 10'd60;
      3'd5:    credit = 10'd90;
      3'd6:    credit = 10'd120;
      3'd7:    credit = 10'd300;
      default: credit = 10'd0;
    endcase
  end

  always_comb begin
    accept = ModeEnable && (Coin != 3'd0) && (Coin != prev_q);
    tick   = ModeEnable && (pre_q == PRE_MAX);

    secs = {6'd0, time_q[11:8]} * 10'd60 + {6'd0, time_q[7:4]} * 10'd10 + {6'd0, time_q[3:0]};
    // A coin edge only adds credit; the tick on that edge is dropped.
    t1   = (tick && secs != 10'd0 && !accept) ? secs - 10'd1 : secs;
    sum  = {1'b0, t1} + {1'b0, (accept ? credit : 10'd0)};
    t2   = (sum > {1'b0, T_MAX}) ? T_MAX : sum[9:0];

    m_dig = 4'(t2 / 10'd60);
    rem_s = t2 - 10'd60 * {6'd0, m_dig};
    t_dig = 4'(rem_s / 10'd10);
    s_dig = 4'(rem_s - 10'd10 * {6'd0, t_dig});

    time_d = time_q;
    pre_d  = pre_q;
    if (ModeEnable) begin
      time_d = {m_dig, t_dig, s_dig};
      pre_d  = tick ? '0 : pre_q + 1'b1;
    end
    // Coin history tracks even while frozen, so a coin held across re-enable is not credited.
    prev_d = Coin;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      time_q <= 12'h000;
      prev_q <= 3'd0;
      pre_q  <= '0;
    end else begin
      time_q <= time_d;
      prev_q <= prev_d;
      pre_q  <= pre_d;
    end
  end

  assign PresentTime = time_q;

endmodule

// File: tb/tb_counter_main.sv
// Bench for counter_main: TICK_DIV=1 and TICK_DIV=4 instances share stimulus,
// a seconds-based reference model feeds a scoreboard, plus constant vector tables.
module tb_counter_main;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        ModeEnable;
  logic [2:0]  Coin;
  logic [11:0] pt1, pt4;

  counter_main #(.TICK_DIV(1)) dut1 (
    .Clk(Clk), .nReset(nReset), .ModeEnable(ModeEnable), .Coin(Coin), .PresentTime(pt1));
  counter_main #(.TICK_DIV(4)) dut4 (
    .Clk(Clk), .nReset(nReset), .ModeEnable(ModeEnable), .Coin(Coin), .PresentTime(pt4));

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  int m_t [2];
  int m_prev [2];
  int m_pre [2];
  int div_c [2] = '{1, 4};
  logic [11:0] q1 [$];
  logic [11:0] q4 [$];

  typedef struct {
    logic        rst;
    logic        mode;
    logic [2:0]  coin;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [11:0] to_bcd(input int t);
    return {4'(t / 60), 4'((t % 60) / 10), 4'(t % 10)};
  endfunction

  function automatic int coin_secs(input logic [2:0] c);
    case (c)
      3'd1: return 10;
      3'd2: return 20;
      3'd3: return 30;
      3'd4: return 60;
      3'd5: return 90;
      3'd6: return 120;
      3'd7: return 300;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_prev[k] = 0; m_pre[k] = 0;
    end
  endtask

  task automatic model_step(input logic mode, input logic [2:0] coin);
    for (int k = 0; k < 2; k++) begin
      bit acc, tk;
      int t;
      acc = mode && coin != 0 && int'(coin) != m_prev[k];
      tk  = mode && m_pre[k] == div_c[k] - 1;
      if (mode) begin
        t = m_t[k];
        if (tk && t != 0 && !acc) t = t - 1;
        if (acc) t = t + coin_secs(coin);
        if (t > 599) t = 599;
        m_t[k]   = t;
        m_pre[k] = tk ? 0 : m_pre[k] + 1;
      end
      m_prev[k] = int'(coin);
    end
    q1.push_back(to_bcd(m_t[0]));
    q4.push_back(to_bcd(m_t[1]));
  endtask

  // Drive at the falling edge, check 1ns after the rising edge, return at the next falling edge.
  task automatic step(input logic mode, input logic [2:0] coin);
    ModeEnable = mode;
    Coin       = coin;
    model_step(mode, coin);
    @(posedge Clk);
    #1;
    chk("sb_div1", pt1, q1.pop_front());
    chk("sb_div4", pt4, q4.pop_front());
    @(negedge Clk);
  endtask

  task automatic do_reset();
    #2;
    nReset = 1'b0;
    #1;
    chk("async_rst_div1", pt1, 12'h000);
    chk("async_rst_div4", pt4, 12'h000);
    model_reset();
    @(posedge Clk);
    #1;
    chk("rst_held_div1", pt1, 12'h000);
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic add(input logic r, input logic m, input logic [2:0] c, input logic [11:0] e);
    vecs.push_back('{r, m, c, e});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // coin sequences from 0:00: 4,0,4 then 3,7 back-to-back
    add(0, 1, 3'd0, 12'h000);
    add(0, 1, 3'd4, 12'h100);
    add(0, 1, 3'd0, 12'h059);
    add(0, 1, 3'd4, 12'h159);
    add(0, 1, 3'd0, 12'h158);
    add(0, 1, 3'd3, 12'h228);
    add(0, 1, 3'd7, 12'h728);
    add(0, 1, 3'd0, 12'h727);
    // build 9:00 from distinct consecutive codes, then saturate
    add(1, 1, 3'd7, 12'h500);
    add(0, 1, 3'd6, 12'h700);
    add(0, 1, 3'd4, 12'h800);
    add(0, 1, 3'd3, 12'h830);
    add(0, 1, 3'd2, 12'h850);
    add(0, 1, 3'd1, 12'h900);
    add(0, 1, 3'd7, 12'h959);
    add(0, 1, 3'd0, 12'h958);
    add(0, 1, 3'd7, 12'h959);
    add(0, 1, 3'd7, 12'h958);
    // freeze at 0:45 with a coin pulse, then resume
    add(1, 1, 3'd3, 12'h030);
    add(0, 1, 3'd2, 12'h050);
    add(0, 1, 3'd0, 12'h049);
    add(0, 1, 3'd0, 12'h048);
    add(0, 1, 3'd0, 12'h047);
    add(0, 1, 3'd0, 12'h046);
    add(0, 1, 3'd0, 12'h045);
    for (int i = 0; i < 20; i++) add(0, 0, (i == 5) ? 3'd4 : 3'd0, 12'h045);
    add(0, 1, 3'd0, 12'h044);
    add(0, 1, 3'd0, 12'h043);

    nReset     = 1'b0;
    ModeEnable = 1'b1;
    Coin       = 3'd5;
    model_reset();
    #2;
    chk("rst_init_div1", pt1, 12'h000);
    chk("rst_init_div4", pt4, 12'h000);
    @(posedge Clk);
    #1;
    chk("rst_init_held", pt1, 12'h000);
    @(negedge Clk);
    nReset = 1'b1;

    // coin 5 held: 1:30 then count to 0:00 and hold with no re-credit
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 3'd5);
      if (i == 0)   chk("first_edge_130", pt1, 12'h130);
      if (i == 1)   chk("second_edge_129", pt1, 12'h129);
      if (i == 30)  chk("at_100", pt1, 12'h100);
      if (i == 31)  chk("borrow_059", pt1, 12'h059);
      if (i == 80)  chk("at_010", pt1, 12'h010);
      if (i == 81)  chk("borrow_009", pt1, 12'h009);
      if (i == 90)  chk("zero_at_915", pt1, 12'h000);
      if (i == 199) chk("zero_hold", pt1, 12'h000);
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].mode, vecs[i].coin);
      chk($sformatf("vec%0d", i), pt1, vecs[i].exp);
    end

    // TICK_DIV=4: one decrement per 4 enabled edges, then async reset mid-count
    do_reset();
    step(1'b1, 3'd1);
    chk("div4_credit", pt4, 12'h010);
    step(1'b1, 3'd0); chk("div4_e2", pt4, 12'h010);
    step(1'b1, 3'd0); chk("div4_e3", pt4, 12'h010);
    step(1'b1, 3'd0); chk("div4_e4", pt4, 12'h009);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0);
      chk("div4_hold", pt4, 12'h009);
    end
    step(1'b1, 3'd0); chk("div4_e8", pt4, 12'h008);
    step(1'b1, 3'd0);
    do_reset();
    step(1'b1, 3'd0);
    chk("post_rst_div4", pt4, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
